// File: rtl/i2s_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : i2s_voice_scheduler
// Description : Polls each enabled voice once per sample period and sums the
//               voices into saturated left/right channels. Optional macro
//               VOICE_ACK_TIMEOUT_EN bounds each handshake to 16 request cycles.
// Revision    : 1.0  initial release
// ============================================================================
module i2s_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_DIV = 520,
    parameter int WIDTH      = 16,
    localparam int SEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [NUM_VOICES-1:0] i_Voice_Enable,
    output logic                  o_Voice_Req,
    output logic [SEL_W-1:0]      o_Voice_Sel,
    input  logic                  i_Voice_Ack,
    input  logic [WIDTH-1:0]      i_Voice_Data,
    output logic [WIDTH-1:0]      o_Sample_Left,
    output logic [WIDTH-1:0]      o_Sample_Right,
    output logic                  o_Sample_Valid,
    output logic                  o_Overrun,
    output logic                  o_Ack_Timeout
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int ACC_W = WIDTH + SEL_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2,
        ST_SAT  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]  acc_r_q, acc_r_d;
    logic [WIDTH-1:0]         left_q, left_d;
    logic [WIDTH-1:0]         right_q, right_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    logic                     w_tick;
    logic                     w_timeout;
    logic signed [ACC_W-1:0]  w_data_ext;

    function automatic logic [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (a < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return a[WIDTH-1:0];
        end
    endfunction

    assign w_tick     = (cnt_q == CNT_LAST);
    assign w_data_ext = {{(ACC_W-WIDTH){i_Voice_Data[WIDTH-1]}}, i_Voice_Data};

    always_comb begin
        cnt_d = w_tick ? '0 : cnt_q + CNT_W'(1);
    end

`ifdef VOICE_ACK_TIMEOUT_EN
    logic [3:0] to_cnt_q, to_cnt_d;
    logic       ack_to_q, ack_to_d;

    // Counter wraps to 0 on the 16th missed cycle, exactly when WAIT is left.
    always_comb begin
        to_cnt_d = 4'd0;
        ack_to_d = ack_to_q;
        if (state_q == ST_WAIT && !i_Voice_Ack) begin
            to_cnt_d = to_cnt_q + 4'd1;
            if (to_cnt_q == 4'hF) begin
                ack_to_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            to_cnt_q <= 4'd0;
            ack_to_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            ack_to_q <= ack_to_d;
        end
    end

    assign w_timeout     = (to_cnt_q == 4'hF);
    assign o_Ack_Timeout = ack_to_q;
`else
    assign w_timeout     = 1'b0;
    assign o_Ack_Timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (w_tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (i_Voice_Enable[idx_q]) begin
                    state_d = ST_WAIT;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            ST_WAIT: begin
                if (i_Voice_Ack || w_timeout) begin
                    // A timed-out voice contributes nothing to the sum.
                    if (i_Voice_Ack) begin
                        if (idx_q[0]) begin
                            acc_r_d = acc_r_q + w_data_ext;
                        end else begin
                            acc_l_d = acc_l_q + w_data_ext;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_SAT;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SAT: begin
                left_d  = saturate(acc_l_q);
                right_d = saturate(acc_r_q);
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_Voice_Req    = (state_q == ST_WAIT);
    assign o_Voice_Sel    = idx_q;
    assign o_Sample_Left  = left_q;
    assign o_Sample_Right = right_q;
    assign o_Sample_Valid = valid_q;
    assign o_Overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_voice_scheduler
// Description : Directed bench for i2s_voice_scheduler with scripted voice
//               responders on two instances (long and short sample period).
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_voice_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance A: SAMPLE_DIV = 32 ----------------
    logic        rst_a_n = 1'b0;
    logic [3:0]  en_a = 4'hF;
    logic        req_a, ack_a, valid_a, ovr_a, to_a;
    logic [1:0]  sel_a;
    logic [15:0] data_a, l_a, r_a;
    logic signed [15:0] vdata_a [4];
    int          delay_a [4];
    logic        never_a [4];
    int          wcnt_a = 0;
    int          cyc_a = 0;
    int          req_cnt_a = 0;
    int          req3_cnt_a = 0;

    i2s_voice_scheduler #(.NUM_VOICES(4), .SAMPLE_DIV(32), .WIDTH(16)) u_dut_a (
        .i_Clk          (clk),
        .i_Rst_n        (rst_a_n),
        .i_Voice_Enable (en_a),
        .o_Voice_Req    (req_a),
        .o_Voice_Sel    (sel_a),
        .i_Voice_Ack    (ack_a),
        .i_Voice_Data   (data_a),
        .o_Sample_Left  (l_a),
        .o_Sample_Right (r_a),
        .o_Sample_Valid (valid_a),
        .o_Overrun      (ovr_a),
        .o_Ack_Timeout  (to_a)
    );

    always_comb begin
        ack_a  = req_a && !never_a[sel_a] && (wcnt_a >= delay_a[sel_a]);
        data_a = vdata_a[sel_a];
    end

    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) cyc_a <= 0;
        else          cyc_a <= cyc_a + 1;
    end

    always @(posedge clk) begin
        wcnt_a <= (req_a && !ack_a) ? wcnt_a + 1 : 0;
        if (req_a) req_cnt_a <= req_cnt_a + 1;
        if (req_a && sel_a == 2'd3) req3_cnt_a <= req3_cnt_a + 1;
    end

    // ---------------- instance B: SAMPLE_DIV = 8 ----------------
    logic        rst_b_n = 1'b0;
    logic [3:0]  en_b = 4'b0011;
    logic        req_b, ack_b, valid_b, ovr_b, to_b;
    logic [1:0]  sel_b;
    logic [15:0] data_b, l_b, r_b;
    logic signed [15:0] vdata_b [4];
    int          delay_b [4];
    int          wcnt_b = 0;
    int          cyc_b = 0;

    i2s_voice_scheduler #(.NUM_VOICES(4), .SAMPLE_DIV(8), .WIDTH(16)) u_dut_b (
        .i_Clk          (clk),
        .i_Rst_n        (rst_b_n),
        .i_Voice_Enable (en_b),
        .o_Voice_Req    (req_b),
        .o_Voice_Sel    (sel_b),
        .i_Voice_Ack    (ack_b),
        .i_Voice_Data   (data_b),
        .o_Sample_Left  (l_b),
        .o_Sample_Right (r_b),
        .o_Sample_Valid (valid_b),
        .o_Overrun      (ovr_b),
        .o_Ack_Timeout  (to_b)
    );

    always_comb begin
        ack_b  = req_b && (wcnt_b >= delay_b[sel_b]);
        data_b = vdata_b[sel_b];
    end

    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) cyc_b <= 0;
        else          cyc_b <= cyc_b + 1;
    end

    always @(posedge clk) begin
        wcnt_b <= (req_b && !ack_b) ? wcnt_b + 1 : 0;
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid_a(input string tag, output int cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < 300);
        check_val({tag, "_valid_seen"}, {31'd0, valid_a}, 1);
        cyc = cyc_a;
    endtask

    task automatic wait_valid_b(input string tag, output int cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_b && n < 300);
        check_val({tag, "_valid_seen"}, {31'd0, valid_b}, 1);
        cyc = cyc_b;
    endtask

    task automatic set_data_a(input int d0, input int d1, input int d2, input int d3);
        vdata_a[0] = 16'(d0);
        vdata_a[1] = 16'(d1);
        vdata_a[2] = 16'(d2);
        vdata_a[3] = 16'(d3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int base;
        int n;
        for (int i = 0; i < 4; i++) begin
            delay_a[i] = 0;
            never_a[i] = 1'b0;
            delay_b[i] = 0;
            vdata_b[i] = 16'sd0;
        end
        set_data_a(1000, 2000, 3000, 4000);
        vdata_b[0] = 16'sd111;
        vdata_b[1] = -16'sd222;

        repeat (3) @(negedge clk);
        check_val("rst_req",   {31'd0, req_a}, 0);
        check_val("rst_sel",   {30'd0, sel_a}, 0);
        check_val("rst_L",     $signed(l_a), 0);
        check_val("rst_R",     $signed(r_a), 0);
        check_val("rst_valid", {31'd0, valid_a}, 0);
        check_val("rst_ovr",   {31'd0, ovr_a}, 0);
        check_val("rst_to",    {31'd0, to_a}, 0);
        check_val("rst_b_valid", {31'd0, valid_b}, 0);

        // Test 1: all voices, zero-wait acks; tick at cycle 31
        rst_a_n = 1'b1;
        wait_valid_a("t1", c);
        check_val("t1_latency", c, 41);
        check_val("t1_L", $signed(l_a), 4000);
        check_val("t1_R", $signed(r_a), 6000);
        @(negedge clk);
        check_val("t1_pulse_width", {31'd0, valid_a}, 0);
        check_val("t1_hold_L", $signed(l_a), 4000);

        // Test 3: all disabled; tick at 63
        en_a = 4'b0000;
        base = req_cnt_a;
        wait_valid_a("t3", c);
        check_val("t3_latency", c, 69);
        check_val("t3_L", $signed(l_a), 0);
        check_val("t3_R", $signed(r_a), 0);
        check_val("t3_req_cycles", req_cnt_a - base, 0);
        @(negedge clk);

        // Mixed mask with ack waits: 2 + 2 + 2*2 + (2+3) = 13; tick at 95
        en_a = 4'b1010;
        set_data_a(7777, -1234, 7777, 234);
        delay_a[1] = 2;
        delay_a[3] = 3;
        wait_valid_a("t2b", c);
        check_val("t2b_latency", c, 108);
        check_val("t2b_L", $signed(l_a), 0);
        check_val("t2b_R", $signed(r_a), -1000);
        @(negedge clk);

        // Test 2: saturation; tick at 127
        en_a = 4'hF;
        delay_a[1] = 0;
        delay_a[3] = 0;
        set_data_a(30000, -30000, 30000, -30000);
        wait_valid_a("t2", c);
        check_val("t2_latency", c, 137);
        check_val("t2_L", $signed(l_a), 32767);
        check_val("t2_R", $signed(r_a), -32768);
        check_val("t2_ovr", {31'd0, ovr_a}, 0);
        @(negedge clk);

        // Test 5: reset while waiting on voice 2
        delay_a[2] = 10;
        n = 0;
        while (!(req_a && sel_a == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_in_wait2", {31'd0, (req_a && sel_a == 2'd2)}, 1);
        rst_a_n = 1'b0;
        #1;
        check_val("t5_req",   {31'd0, req_a}, 0);
        check_val("t5_sel",   {30'd0, sel_a}, 0);
        check_val("t5_L",     $signed(l_a), 0);
        check_val("t5_R",     $signed(r_a), 0);
        check_val("t5_valid", {31'd0, valid_a}, 0);
        repeat (2) @(negedge clk);
        delay_a[2] = 0;
        set_data_a(1000, 2000, 3000, 4000);
        rst_a_n = 1'b1;
        wait_valid_a("t5_after", c);
        check_val("t5_after_latency", c, 41);
        check_val("t5_after_L", $signed(l_a), 4000);
        check_val("t5_after_R", $signed(r_a), 6000);
        @(negedge clk);

`ifdef VOICE_ACK_TIMEOUT_EN
        // Test 6: voice 3 silent; 7 + 16 + SAT + 1 = 25 cycles after tick 63
        never_a[3] = 1'b1;
        set_data_a(100, 200, 300, 999);
        base = req3_cnt_a;
        wait_valid_a("t6", c);
        check_val("t6_latency", c, 88);
        check_val("t6_L", $signed(l_a), 400);
        check_val("t6_R", $signed(r_a), 200);
        check_val("t6_to", {31'd0, to_a}, 1);
        check_val("t6_req3_cycles", req3_cnt_a - base, 16);
        check_val("t6_req_low", {31'd0, req_a}, 0);
        check_val("t6_ovr", {31'd0, ovr_a}, 0);
`else
        check_val("to_tied_low", {31'd0, to_a}, 0);
`endif

        // Test 4: short period; tick at 7, then 15, 23 (dropped), 31
        rst_b_n = 1'b1;
        wait_valid_b("t4a", c);
        check_val("t4a_latency", c, 15);
        check_val("t4a_L", $signed(l_b), 111);
        check_val("t4a_R", $signed(r_b), -222);
        check_val("t4a_ovr", {31'd0, ovr_b}, 0);
        delay_b[1] = 6;
        wait_valid_b("t4b", c);
        check_val("t4b_latency", c, 29);
        check_val("t4b_L", $signed(l_b), 111);
        check_val("t4b_R", $signed(r_b), -222);
        check_val("t4b_ovr", {31'd0, ovr_b}, 1);
        delay_b[1] = 0;
        vdata_b[0] = 16'sd5;
        vdata_b[1] = 16'sd7;
        wait_valid_b("t4c", c);
        check_val("t4c_latency", c, 39);
        check_val("t4c_L", $signed(l_b), 5);
        check_val("t4c_R", $signed(r_b), 7);
        check_val("t4c_ovr_sticky", {31'd0, ovr_b}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
